// File: rtl/eeprom_req_arbiter.sv
// Two-port round-robin arbiter and single-byte sequencer for the EEPROM_WR parallel bus.
// Define ARB_TIMEOUT_EN to bound the ACK wait and report err0/err1 on expiry.
module eeprom_req_arbiter #(
   parameter int unsigned GAP_CYCLES     = 5,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        req0,
   input  logic        wr0,
   input  logic [10:0] addr0,
   input  logic [7:0]  wdata0,
   output logic        done0,
   output logic        err0,
   input  logic        req1,
   input  logic        wr1,
   input  logic [10:0] addr1,
   input  logic [7:0]  wdata1,
   output logic        done1,
   output logic        err1,
   output logic [7:0]  rdata,
   output logic        RD,
   output logic        WR,
   output logic [10:0] ADDR,
   input  logic        ACK,
   inout  wire  [7:0]  DATA
);
   localparam int unsigned AW = 11;
   localparam int unsigned DW = 8;
   localparam int unsigned GW = 8;
   localparam int unsigned TW = 13;

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_PULSE, S_WAIT, S_DONE, S_GAP
   } state_t;

   state_t        r_state, w_state_nxt;
   logic          r_ack_q, w_ack_rise, w_timeout;
   logic          w_sel, w_sel_wr;
   logic [AW-1:0] w_sel_addr, r_addr;
   logic [DW-1:0] w_sel_wdata, r_wdata, r_rdata;
   logic          r_gnt, r_rr, r_lwr, r_oe, r_rd, r_wr, r_done0, r_done1;
   logic [GW-1:0] r_gcnt;

   assign w_ack_rise  = ACK & ~r_ack_q;
   assign w_sel       = (req0 & req1) ? r_rr : req1;
   assign w_sel_wr    = w_sel ? wr1 : wr0;
   assign w_sel_addr  = w_sel ? addr1 : addr0;
   assign w_sel_wdata = w_sel ? wdata1 : wdata0;

   assign RD    = r_rd;
   assign WR    = r_wr;
   assign ADDR  = r_addr;
   assign rdata = r_rdata;
   assign done0 = r_done0;
   assign done1 = r_done1;
   assign DATA  = r_oe ? r_wdata : 8'bz;

`ifdef ARB_TIMEOUT_EN
   logic [TW-1:0] r_tcnt;
   logic          r_err0, r_err1;

   // r_tcnt counts cycles since the strobe, so DONE lands TIMEOUT_CYCLES after PULSE
   assign w_timeout = (r_tcnt == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_tcnt <= '0;
         r_err0 <= 1'b0;
         r_err1 <= 1'b0;
      end else begin
         r_err0 <= 1'b0;
         r_err1 <= 1'b0;
         if (r_state == S_PULSE) begin
            r_tcnt <= TW'(1);
         end else if (r_state == S_WAIT) begin
            r_tcnt <= r_tcnt + TW'(1);
            if (w_timeout & ~w_ack_rise) begin
               r_err0 <= ~r_gnt;
               r_err1 <= r_gnt;
            end
         end
      end
   end

   assign err0 = r_err0;
   assign err1 = r_err1;
`else
   wire [TW-1:0] w_unused_timeout = TW'(TIMEOUT_CYCLES);

   assign w_timeout = 1'b0;
   assign err0      = 1'b0;
   assign err1      = 1'b0;
`endif

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (req0 | req1) w_state_nxt = S_SETUP;
         S_SETUP: w_state_nxt = S_PULSE;
         S_PULSE: w_state_nxt = S_WAIT;
         S_WAIT:  if (w_ack_rise | w_timeout) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_GAP;
         S_GAP:   if (r_gcnt == GW'(GAP_CYCLES - 1)) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Transaction datapath; strobes and done are single-cycle by default clearing
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_ack_q <= 1'b0;
         r_gnt   <= 1'b0;
         r_rr    <= 1'b0;
         r_lwr   <= 1'b0;
         r_oe    <= 1'b0;
         r_rd    <= 1'b0;
         r_wr    <= 1'b0;
         r_done0 <= 1'b0;
         r_done1 <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_gcnt  <= '0;
      end else begin
         r_ack_q <= ACK;
         r_rd    <= 1'b0;
         r_wr    <= 1'b0;
         r_done0 <= 1'b0;
         r_done1 <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (req0 | req1) begin
                  r_gnt   <= w_sel;
                  r_lwr   <= w_sel_wr;
                  r_addr  <= w_sel_addr;
                  r_wdata <= w_sel_wdata;
                  r_oe    <= w_sel_wr;
               end
            end
            S_SETUP: begin
               r_rd <= ~r_lwr;
               r_wr <= r_lwr;
            end
            S_WAIT: begin
               if (w_ack_rise | w_timeout) begin
                  r_oe    <= 1'b0;
                  r_done0 <= ~r_gnt;
                  r_done1 <= r_gnt;
                  if (w_ack_rise & ~r_lwr) r_rdata <= DATA;
               end
            end
            S_DONE: begin
               r_rr   <= ~r_gnt;
               r_gcnt <= '0;
            end
            S_GAP:   r_gcnt <= r_gcnt + GW'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: doc/eeprom_req_arbiter.md
Name: eeprom_req_arbiter

Overview:
- Two-port round-robin arbiter and sequencer for the shared EEPROM_WR parallel interface (RD, WR, ADDR, ACK, DATA).
- Each requester posts a single-byte read or write. The block sequences the RD/WR pulse, waits for the ACK rising edge, returns read data, and enforces an inter-transaction gap.
- Sits between system masters and the EEPROM_WR parallel-to-I2C converter.

Parameters:
- GAP_CYCLES, 5: idle cycles between the end of one transaction and the next grant; legal range 1..255.
- TIMEOUT_CYCLES, 4096: ACK wait limit in cycles; used only when ARB_TIMEOUT_EN is defined.

Ports:
- CLK  input  1  system clock; rising edge active.
- RESET  input  1  asynchronous, active-high reset.
- req0  input  1  requester 0 transaction request; level, held until done0.
- wr0  input  1  requester 0 direction; 1 = write, 0 = read.
- addr0  input  11  requester 0 EEPROM byte address.
- wdata0  input  8  requester 0 write data.
- done0  output  1  one-cycle completion pulse to requester 0.
- err0  output  1  one-cycle timeout flag, coincident with done0.
- req1, wr1, addr1, wdata1, done1, err1: same as above, for requester 1.
- rdata  output  8  read data from the last completed read; holds until the next read completes.
- RD  output  1  read strobe to EEPROM_WR.
- WR  output  1  write strobe to EEPROM_WR.
- ADDR  output  11  address to EEPROM_WR.
- ACK  input  1  EEPROM_WR completion; synchronous to CLK.
- DATA  inout  8  bidirectional data bus.

Behaviour:
- Reset values: RD=0, WR=0, ADDR=0, rdata=0, done0/1=0, err0/1=0, DATA high-Z, rr pointer=0 (requester 0 has priority), state=IDLE, ack_q=0.
- ACK edge detect: ack_q registers ACK; ack_rise = ACK & ~ack_q.
- IDLE:
  - If any req is high, grant per round robin. Only one requester: grant it. Both: grant the one rr points to.
  - On grant, latch wr, addr, wdata into internal registers; go to SETUP.
- SETUP (1 cycle):
  - ADDR = latched address.
  - If write, drive DATA = latched wdata. If read, DATA stays high-Z.
- PULSE (1 cycle): WR=1 for a write or RD=1 for a read; exactly one cycle wide. Go to WAIT_ACK.
- WAIT_ACK:
  - ADDR and DATA drive are held stable.
  - On ack_rise: for a read, capture DATA into rdata on that same edge. Go to DONE.
- DONE (1 cycle):
  - Pulse done of the granted requester.
  - Release DATA to high-Z.
  - rr points to the other requester.
  - Go to GAP.
- GAP: count GAP_CYCLES cycles, then go to IDLE. ADDR retains its last value.
- Latency: req high in IDLE at cycle 0 gives ADDR valid at cycle 1 and the strobe at cycle 2. done is asserted in the cycle after the edge on which ack_rise is sampled.
- Request rules:
  - req is sampled only in IDLE.
  - Latched fields are immune to requester changes mid-transaction.
  - Dropping req mid-transaction does not abort it; done still pulses.
  - A requester must drop req before GAP ends, or it re-enters arbitration.
- ACK edge cases:
  - ACK already high when entering WAIT_ACK does not count; a fresh rising edge is required.
  - An ACK edge outside WAIT_ACK is ignored.
- RD and WR are never both high.
- DATA is never driven during reads, DONE, GAP or IDLE.
- Asynchronous RESET mid-transaction: return immediately to reset values. No done is issued for the aborted transaction.

Optional Feature:
- ARB_TIMEOUT_EN defined:
  - A 13-bit counter runs in WAIT_ACK.
  - On reaching TIMEOUT_CYCLES without ack_rise, go to DONE with err of the granted requester = 1 alongside done.
  - rdata is unchanged; rr advances normally.
- ARB_TIMEOUT_EN undefined: WAIT_ACK waits indefinitely; err0 and err1 are tied 0.

Test Plan:
- Write path: req0=1, wr0=1, addr0=11'h123, wdata0=8'hA5.
  - Expect ADDR=123 from cycle 1, WR pulse at cycle 2, DATA=A5 driven.
  - ACK rise at cycle 10 gives done0 at cycle 11 and DATA high-Z at cycle 11.
- Read path: req1=1, wr1=0, addr1=11'h7FF; model drives DATA=8'h3C with ACK.
  - Expect exactly one RD pulse and DATA never driven by the block.
  - rdata=3C, done1 one cycle.
- Contention: req0 and req1 both held high for 4 transactions.
  - Grants alternate 0,1,0,1; gap between done and next strobe = GAP_CYCLES+2 cycles.
- ACK pre-high: ACK held high before PULSE; expect no completion until ACK falls and rises again.
- Mid-transaction reset: RESET=1 during WAIT_ACK; expect RD/WR=0, ADDR=0, DATA high-Z immediately, no done.
  - After release, a new req0 completes normally.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16): no ACK; expect done0=1 and err0=1 16 cycles after PULSE, rdata unchanged.
